// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer, the PLL it controls and the core it releases.
// The master side is the sequencer; the slave side is the PLL/core environment.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] timeout_count;
  logic [7:0] relock_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_reset,
    output ready,
    output timeout_count,
    output relock_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_reset,
    input  ready,
    input  timeout_count,
    input  relock_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, waits for lock with timeout/retry, qualifies lock,
// then releases the core system reset. Runs entirely on the free-running reference clock.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024
) (
  input logic                   refclk,
  input logic                   rst,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_A      = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PULSE     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       sync_r;
  logic             locked_s;
  logic             timeout_inc_s;
  logic             relock_inc_s;
  logic             pll_rst_r;
  logic             sys_reset_r;
  logic             ready_r;
  logic [7:0]       timeout_count_r;
  logic [7:0]       relock_count_r;

  assign locked_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], bus.pll_locked};
    end
  end

  // Next-state decode; lock is checked ahead of the timeout in WAIT_LOCK.
  always_comb begin
    state_s       = state_r;
    timeout_inc_s = 1'b0;
    relock_inc_s  = 1'b0;
    case (state_r)
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = WAIT_LOCK;
        end else begin
          state_s = PULSE;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_s = STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s       = PULSE;
          timeout_inc_s = 1'b1;
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = RUN;
        end else begin
          state_s = STABLE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_s      = WAIT_LOCK;
          relock_inc_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = PULSE;
      end
    endcase
  end

  // State, shared interval counter and registered outputs decoded from the next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= PULSE;
      cnt_r       <= {CNT_W{1'b0}};
      pll_rst_r   <= 1'b1;
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pll_rst_r   <= (state_s == PULSE);
      sys_reset_r <= (state_s != RUN);
      ready_r     <= (state_s == RUN);
      // RUN has no terminal count, so the counter holds there instead of wrapping.
      if (state_s != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != RUN) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Saturating event counters for lock timeouts and lock losses in RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      timeout_count_r <= 8'd0;
      relock_count_r  <= 8'd0;
    end else begin
      if (timeout_inc_s && (timeout_count_r != 8'hFF)) begin
        timeout_count_r <= timeout_count_r + 8'd1;
      end else begin
        timeout_count_r <= timeout_count_r;
      end
      if (relock_inc_s && (relock_count_r != 8'hFF)) begin
        relock_count_r <= relock_count_r + 8'd1;
      end else begin
        relock_count_r <= relock_count_r;
      end
    end
  end

  assign bus.pll_rst       = pll_rst_r;
  assign bus.sys_reset     = sys_reset_r;
  assign bus.ready         = ready_r;
  assign bus.timeout_count = timeout_count_r;
  assign bus.relock_count  = relock_count_r;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset-side companion to the core PLL wrapper: drives the PLL's `rst` input and consumes its asynchronous `locked` output. Pulses PLL reset, waits for lock with a timeout and retry, qualifies lock for a stable interval, and only then releases the core's synchronous system reset. Runs on the 50 MHz reference clock so it keeps operating while the PLL outputs are absent or unstable.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per reset pulse (>=2).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles to wait for lock before re-pulsing (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.

Ports:
- `refclk`  in  1  50 MHz free-running reference clock; sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous to `refclk`.
- `pll_rst`  out  1  drives PLL `rst`; active-high.
- `sys_reset`  out  1  active-high reset for core logic.
- `ready`  out  1  high only in RUN.
- `timeout_count`  out  8  lock timeouts since `rst`; saturates at 255.
- `relock_count`  out  8  lock losses in RUN since `rst`; saturates at 255.

## Operation
- `pll_locked` passes a 2-flop synchronizer -> `locked_s`. Only `locked_s` is used.
- FSM states: PULSE, WAIT_LOCK, STABLE, RUN. One shared counter `cnt`, cleared on every state entry.
- PULSE: `pll_rst`=1, `sys_reset`=1. `locked_s` ignored. When `cnt`==RST_PULSE_CYCLES-1 -> WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_reset`=1. If `locked_s`=1 -> STABLE. Else if `cnt`==LOCK_TIMEOUT_CYCLES-1 -> PULSE, `timeout_count`++ (saturating). Lock check has priority over timeout in the same cycle.
- STABLE: `pll_rst`=0, `sys_reset`=1. If `locked_s`=0 -> WAIT_LOCK (counter restarts, no count increment). Else if `cnt`==STABLE_CYCLES-1 -> RUN.
- RUN: `pll_rst`=0, `sys_reset`=0, `ready`=1. If `locked_s`=0 -> WAIT_LOCK, `relock_count`++ (saturating). No PLL re-pulse on lock loss unless the subsequent wait times out.
- Counter width: clog2 of the largest parameter; never wraps, since every state exits at its terminal value.
- All outputs registered (decoded from next state), so they change on the same edge as the state register.

## Timing
- Reset values: state=PULSE, `cnt`=0, synchronizer=0, `pll_rst`=1, `sys_reset`=1, `ready`=0, both counts=0.
- `rst` asserted at any time, mid-state included: all of the above apply immediately (asynchronous). Counts are cleared.
- After `rst` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYCLES `refclk` edges, then falls.
- `pll_locked` -> `locked_s`: 2 cycles. `locked_s` -> STABLE entry: 1 cycle.
- Lock-to-release latency: `sys_reset` falls 2 + 1 + STABLE_CYCLES edges after `pll_locked` is sampled high, assuming it stays high.
- Lock loss in RUN: `sys_reset` rises and `ready` falls 3 edges after `pll_locked` is sampled low.
- A glitch on `pll_locked` shorter than one cycle may be missed. This is acceptable.
- A glitch of one cycle or longer during STABLE restarts qualification.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8.
- Reset then nominal lock: release `rst`, raise `pll_locked` 10 cycles later -> `pll_rst` high for 4 cycles after release; `sys_reset` falls and `ready` rises 11 edges after `pll_locked` is sampled high; both counts 0.
- No lock: hold `pll_locked`=0 -> `pll_rst` re-pulses for 4 cycles every 24 cycles; `timeout_count` increments 1, 2, 3 and saturates at 255 over a long run.
- Unstable lock: in STABLE, drop `pll_locked` for 2 cycles at `cnt`=5 -> FSM returns to WAIT_LOCK; release happens only after a full fresh 8-cycle qualification; `relock_count` stays 0.
- Loss in RUN: drop `pll_locked` for 3 cycles -> `sys_reset`=1 and `ready`=0 3 edges later; `relock_count`=1; no `pll_rst` pulse; re-release after relock plus 11 cycles.
- Async reset mid-operation: assert `rst` in RUN, between clock edges -> `pll_rst`=1, `sys_reset`=1, `ready`=0 before the next edge; counts return to 0; full sequence repeats.
- Lock at timeout edge: `locked_s` rises in the same cycle `cnt`=19 -> FSM enters STABLE, no re-pulse, `timeout_count` unchanged.
